// File: rtl/fp_mul_pipe_pkg.sv
// Shared FP16 MAC definitions: field widths, bias, constant magnitudes and the
// stage records carried down the multiplier pipeline.
package fp_mul_pipe_pkg;

  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int BIAS   = 15;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int ESUM_W = 7;

  localparam logic [14:0] SAT_MAG  = 15'h7BFF;
  localparam logic [14:0] ZERO_MAG = 15'h0000;

  typedef logic signed [ESUM_W-1:0] esum_t;

  localparam esum_t EXP_MAX = esum_t'(2**EXP_W - 1);

  typedef struct packed {
    logic             sign;
    logic             zero;
    esum_t            exp;
    logic [SIG_W-1:0] ma;
    logic [SIG_W-1:0] mb;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    esum_t             exp;
    logic [PROD_W-1:0] prod;
  } s2_t;

  // Subnormals are flushed, so a zero exponent field means the operand is zero.
  function automatic logic is_zero(input logic [15:0] x);
    return x[MAN_W+EXP_W-1:MAN_W] == '0;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/product streaming bus of the FP16 multiplier, valid/ready on both sides.
interface fp_mul_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/fp_mul_norm.sv
// Normalize a raw 22-bit significand product and apply zero/underflow/overflow,
// producing a truncated FP16 result. Purely combinational.
module fp_mul_norm
  import fp_mul_pipe_pkg::*;
(
  input  logic              sign,
  input  logic              zero,
  input  esum_t             exp,
  input  logic [PROD_W-1:0] prod,
  output logic [15:0]       result
);

  esum_t            exp_n;
  logic [MAN_W-1:0] man;

  // NOTE: every branch assigns every output, so no latch can be inferred.
  always_comb begin
    if (prod[PROD_W-1]) begin
      exp_n = exp + esum_t'(1);
      man   = prod[PROD_W-2 -: MAN_W];
    end else begin
      exp_n = exp;
      man   = prod[PROD_W-3 -: MAN_W];
    end

    if (zero || exp_n <= esum_t'(0))
      result = {sign, ZERO_MAG};
    else if (exp_n >= EXP_MAX)
      result = {sign, SAT_MAG};
    else
      result = {sign, exp_n[EXP_W-1:0], man};
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined FP16 multiplier: S1 unpack, S2 significand multiply,
// S3 normalize/saturate. All stages advance together; a full output stalls all.
module fp_mul_pipe
  import fp_mul_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);

  logic             en;
  logic             v1, v2, v3;
  s1_t              s1;
  s2_t              s2;
  logic [TAG_W-1:0] t1, t2, t3;
  logic [15:0]      data3;
  logic [15:0]      norm_result;

  assign en            = !(v3 && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.out_data  = data3;
  assign bus.out_tag   = t3;

  // NOTE: state uses non-blocking assignments so every stage samples the
  // previous stage's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
      t1 <= '0;
    end else if (en) begin
      v1      <= bus.in_valid;
      s1.sign <= bus.in_a[15] ^ bus.in_b[15];
      s1.zero <= is_zero(bus.in_a) || is_zero(bus.in_b);
      s1.exp  <= esum_t'({2'b00, bus.in_a[MAN_W+EXP_W-1:MAN_W]})
               + esum_t'({2'b00, bus.in_b[MAN_W+EXP_W-1:MAN_W]})
               - esum_t'(BIAS);
      s1.ma   <= {1'b1, bus.in_a[MAN_W-1:0]};
      s1.mb   <= {1'b1, bus.in_b[MAN_W-1:0]};
      t1      <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      s2 <= '0;
      t2 <= '0;
    end else if (en) begin
      v2      <= v1;
      s2.sign <= s1.sign;
      s2.zero <= s1.zero;
      s2.exp  <= s1.exp;
      s2.prod <= PROD_W'(s1.ma) * PROD_W'(s1.mb);
      t2      <= t1;
    end
  end

  fp_mul_norm u_norm (
    .sign   (s2.sign),
    .zero   (s2.zero),
    .exp    (s2.exp),
    .prod   (s2.prod),
    .result (norm_result)
  );

  // NOTE: datapath registers are reset too, so out_data/out_tag read as zero
  // after reset rather than leaking a product that was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      data3 <= '0;
      t3    <= '0;
    end else if (en) begin
      v3    <= v2;
      data3 <= norm_result;
      t3    <= t2;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe: basic products, back-to-back
// streaming, FP16 boundaries, output stall and mid-flight reset.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.TAG_W(4)) bus ();

  fp_mul_pipe #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] va [7];
  logic [15:0] vb [7];
  logic [15:0] vp [7];

  initial begin
    int sent, recv, stall_n;
    logic first_seen;

    va[0] = 16'h3E00; vb[0] = 16'h3E00; vp[0] = 16'h4080;
    va[1] = 16'hC000; vb[1] = 16'h4200; vp[1] = 16'hC600;
    va[2] = 16'h4000; vb[2] = 16'h4000; vp[2] = 16'h4400;
    va[3] = 16'h7800; vb[3] = 16'h4000; vp[3] = 16'h7BFF;
    va[4] = 16'h0400; vb[4] = 16'h0400; vp[4] = 16'h0000;
    va[5] = 16'h8400; vb[5] = 16'h0400; vp[5] = 16'h8000;
    va[6] = 16'h0000; vb[6] = 16'h7BFF; vp[6] = 16'h0000;

    drive(1'b0, 16'h0, 16'h0, 4'h0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  16'h0000);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_in_ready",  bus.in_ready,  1);

    // Latency counts the accepting edge: output is valid after the third edge.
    drive(1'b1, 16'h3C00, 16'h3C00, 4'd3);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    step();
    check("one_early_valid", bus.out_valid, 0);
    step();
    check("one_valid", bus.out_valid, 1);
    check("one_data",  bus.out_data,  16'h3C00);
    check("one_tag",   bus.out_tag,   3);
    step();

    for (int i = 0; i < 9; i++) begin
      if (i < 7) drive(1'b1, va[i], vb[i], 4'(i));
      else       drive(1'b0, 16'h0, 16'h0, 4'h0);
      step();
      if (i >= 2) begin
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_data",  bus.out_data,  vp[i-2]);
        check("b2b_tag",   bus.out_tag,   i - 2);
      end
    end
    step();
    check("b2b_drained", bus.out_valid, 0);

    // Stream six items of 1.0 * b (product == b), stalling six cycles at first output.
    sent = 0; recv = 0; stall_n = 0; first_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      if (bus.out_valid && !first_seen) first_seen = 1'b1;
      bus.out_ready = !(first_seen && stall_n < 6);
      if (!bus.out_ready) stall_n++;
      drive(sent < 6, 16'h3C00, 16'h4000 + 16'(sent) * 16'h0400, 4'(sent));
      #1;
      if (!bus.out_ready) begin
        check("stall_in_ready",  bus.in_ready,  0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_hold_data", bus.out_data,  16'h4000 + 16'(recv) * 16'h0400);
        check("stall_hold_tag",  bus.out_tag,   recv);
      end else begin
        check("open_in_ready", bus.in_ready, 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream_data", bus.out_data, 16'h4000 + 16'(recv) * 16'h0400);
        check("stream_tag",  bus.out_tag,  recv);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    check("stall_all_received", recv, 6);
    check("stall_stall_cycles", stall_n, 6);
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    bus.out_ready = 1'b1;
    check("stall_no_duplicate", bus.out_valid, 0);
    step();
    check("stall_still_empty", bus.out_valid, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h3C00, 16'h4000 + 16'(i) * 16'h0400, 4'(9 + i));
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    check("pre_reset_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data",  bus.out_data,  16'h0000);
    check("reset_out_tag",   bus.out_tag,   0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_no_stale", bus.out_valid, 0);
    end

    drive(1'b1, 16'h3E00, 16'h3E00, 4'd5);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    step();
    check("new_early_valid", bus.out_valid, 0);
    step();
    check("new_valid", bus.out_valid, 1);
    check("new_data",  bus.out_data,  16'h4080);
    check("new_tag",   bus.out_tag,   5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
